usb_rx_pkt_writer: RTL and testbench
====================================

Name: usb_rx_pkt_writer

Overview:
- Upstream feeder of the synchronous packet FIFO in the USB HS receive path.
- Takes the 8-bit UTMI receive byte stream, validates the PID and strips it, withholds the two CRC16 bytes, and checks the CRC16 residue.
- Writes payload bytes into the FIFO's write port.
- Pulses the FIFO commit strobe only for a clean packet. A bad packet is left uncommitted, so the FIFO rewinds it at the next packet start.

Parameters:
- MAX_PKT, 1024, maximum payload bytes; a longer packet is a babble error.
- LSIZE, 11, width of pkt_len; must satisfy 2^LSIZE > MAX_PKT.

Ports:
- CLK  in  1  single clock, UTMI 60 MHz domain
- RST  in  1  synchronous reset, active-high
- rx_data  in  8  UTMI RxData
- rx_valid  in  1  UTMI RxValid; rx_data is meaningful only when high
- rx_active  in  1  UTMI RxActive; high for the whole packet
- rx_error  in  1  UTMI RxError
- fifo_full  in  1  FIFO full flag
- fifo_write  out  1  FIFO write strobe
- fifo_data  out  8  FIFO write data
- fifo_pktval  out  1  FIFO commit pulse, 1 cycle
- fifo_rxact  out  1  FIFO rxact input (packet-start rewind trigger)
- pid  out  4  PID[3:0] of the last data packet
- pkt_len  out  LSIZE  payload length of the last committed packet
- pkt_done  out  1  1-cycle pulse: packet committed
- pkt_err  out  1  1-cycle pulse: packet dropped
- err_code  out  3  reason for the drop: bit0 PID/CRC, bit1 overflow/babble, bit2 rx_error

Behaviour:
- Reset: all outputs 0; state IDLE; hold buffer empty; CRC register 0xFFFF; counters 0.
- fifo_rxact = rx_active registered once (1-cycle latency). All other outputs are registered.

State machine (IDLE, PID, DATA, DROP, CHECK):
- IDLE: on rx_active=1, go to PID; clear the byte count; CRC register = 0xFFFF.
- PID: on the first rx_valid byte:
  - if rx_data[3:0] == ~rx_data[7:4] and rx_data is 0xC3, 0x4B, 0x87 or 0x0F, latch pid and go to DATA;
  - otherwise go to DROP with err bit0.
- DATA, on each rx_valid byte:
  - update the CRC (reflected polynomial 0xA001, LSB first, one byte per cycle) and shift the byte into a 2-byte hold buffer;
  - when the buffer already holds 2 bytes, the oldest byte is emitted: fifo_write=1, fifo_data=that byte on the next cycle, and the payload count increments.
- Write gating in DATA:
  - a byte due to be emitted while fifo_full=1 is not written; set err bit1 and go to DROP;
  - a payload count reaching MAX_PKT+1 is babble: err bit1, go to DROP;
  - rx_error=1 in any non-IDLE state: err bit2, go to DROP.
- DATA to CHECK on rx_active falling.
- DROP: ignores bytes; never writes; on rx_active=0, pulse pkt_err with err_code for 1 cycle, then go to IDLE.
- CHECK, one cycle after the last fifo_write:
  - commit condition: hold buffer full (at least 2 bytes received) and CRC register == 0xB001;
  - on commit: pulse fifo_pktval and pkt_done together; pkt_len = payload count;
  - otherwise: pulse pkt_err with bit0;
  - then go to IDLE. The hold buffer (the CRC bytes) is discarded.
- rx_active falling while in PID: silent return to IDLE, no pulse.
- Timing rules:
  - fifo_pktval never coincides with fifo_write, so the FIFO latches the updated write pointer;
  - the first fifo_write of a packet occurs at least 3 cycles after the fifo_rxact rise, so it never collides with the FIFO rewind cycle. The 2-byte hold plus the PID byte guarantees this at back-to-back rx_valid.
- Zero-length packet (PID + 2 CRC bytes 0x00 0x00): no writes; commit with pkt_len=0.
- Back-to-back packets: a new rx_active rise while in CHECK or DROP is accepted. The state machine reaches IDLE in 1 cycle, before the PID byte can arrive, because UTMI guarantees at least 2 cycles between packets.
- RST asserted mid-packet: return to reset values immediately; remaining bytes of that packet are ignored until rx_active is seen low.

Test Plan:
- DATA0 (0xC3) + payload 01 02 03 04 + valid CRC, back-to-back rx_valid -> 4 writes 01..04; fifo_pktval 1 cycle after the last write; pkt_len=4; pid=3; pkt_done.
- Same packet with one payload byte flipped -> 4 writes, no fifo_pktval; pkt_err with err_code=001; next packet start rewinds the FIFO (FIFO empty stays 1).
- PID 0x69 (IN token), then PID 0xC4 (bad check) -> zero writes; pkt_err err_code=001 each.
- ZLP DATA1 0x4B, 00 00 -> no writes; fifo_pktval; pkt_len=0.
- fifo_full forced high at the 3rd payload byte -> 2 writes; DROP; pkt_err err_code=010; no commit.
- rx_error mid-payload, then MAX_PKT+1 payload bytes, then RST mid-packet -> err_code=100, then 010, then all outputs 0; the following good packet commits normally.

Source files
------------

// File: rtl/usb_rx_pkt_writer.sv
// usb_rx_pkt_writer: strips PID and CRC16 from the UTMI byte stream, writes payload to the packet FIFO, commits clean packets
module usb_rx_pkt_writer #(
  parameter int MAX_PKT = 1024,
  parameter int LSIZE   = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_active,
  input  logic             rx_error,
  input  logic             fifo_full,
  output logic             fifo_write,
  output logic [7:0]       fifo_data,
  output logic             fifo_pktval,
  output logic             fifo_rxact,
  output logic [3:0]       pid,
  output logic [LSIZE-1:0] pkt_len,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [2:0]       err_code
);
  typedef enum logic [2:0] {IDLE, PID, DATA, DROP, CHECK} state_t;
  localparam logic [LSIZE-1:0] MAX_L = LSIZE'(MAX_PKT);
  state_t state, state_d;
  logic [15:0] crc;
  logic [7:0] h0, h1;
  logic [1:0] hn;
  logic [LSIZE-1:0] cnt;
  logic [2:0] err, err_d;
  logic armed, start, take, emit, wr, pid_ok, latch_pid, commit, fail, drop_done;
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'hA001 : r >> 1;
    return r;
  endfunction
  assign emit = hn == 2'd2;
  assign pid_ok = rx_data[3:0] == ~rx_data[7:4] &&
                  (rx_data == 8'hC3 || rx_data == 8'h4B || rx_data == 8'h87 || rx_data == 8'h0F);
  always_comb begin
    state_d = state;
    err_d = err;
    start = 1'b0;
    take = 1'b0;
    wr = 1'b0;
    latch_pid = 1'b0;
    commit = 1'b0;
    fail = 1'b0;
    drop_done = 1'b0;
    case (state)
      IDLE: if (rx_active && armed) begin
        start = 1'b1;
        err_d = 3'b000;
        state_d = PID;
      end
      PID: if (rx_error) begin
        err_d = 3'b100;
        state_d = DROP;
      end else if (!rx_active) state_d = IDLE;
      else if (rx_valid) begin
        latch_pid = pid_ok;
        err_d = pid_ok ? 3'b000 : 3'b001;
        state_d = pid_ok ? DATA : DROP;
      end
      DATA: if (rx_error) begin
        err_d = 3'b100;
        state_d = DROP;
      end else if (!rx_active) state_d = CHECK;
      else if (rx_valid) begin
        // a byte that cannot be written (full FIFO or babble) spoils the packet
        if (emit && (fifo_full || cnt == MAX_L)) begin
          err_d = 3'b010;
          state_d = DROP;
        end else begin
          take = 1'b1;
          wr = emit;
        end
      end
      DROP: begin
        err_d = err | {rx_error, 2'b00};
        if (!rx_active) begin
          drop_done = 1'b1;
          state_d = IDLE;
        end
      end
      CHECK: begin
        commit = emit && crc == 16'hB001;
        fail = !commit;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      err <= 3'b000;
      armed <= 1'b0;
      crc <= 16'hFFFF;
      h0 <= 8'h00;
      h1 <= 8'h00;
      hn <= 2'd0;
      cnt <= '0;
      fifo_write <= 1'b0;
      fifo_data <= 8'h00;
      fifo_pktval <= 1'b0;
      fifo_rxact <= 1'b0;
      pid <= 4'h0;
      pkt_len <= '0;
      pkt_done <= 1'b0;
      pkt_err <= 1'b0;
      err_code <= 3'b000;
    end else begin
      state <= state_d;
      err <= err_d;
      armed <= armed | ~rx_active;
      fifo_rxact <= rx_active;
      fifo_write <= wr;
      fifo_pktval <= commit;
      pkt_done <= commit;
      pkt_err <= fail | drop_done;
      if (wr) fifo_data <= h1;
      if (wr) cnt <= cnt + 1'b1;
      if (latch_pid) pid <= rx_data[3:0];
      if (commit) pkt_len <= cnt;
      if (fail) err_code <= 3'b001;
      else if (drop_done) err_code <= err_d;
      if (start) begin
        cnt <= '0;
        crc <= 16'hFFFF;
        hn <= 2'd0;
      end
      if (take) begin
        crc <= crc_byte(crc, rx_data);
        h1 <= h0;
        h0 <= rx_data;
        hn <= emit ? hn : hn + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_usb_rx_pkt_writer.sv
// tb_usb_rx_pkt_writer: table-driven packet vectors plus reset-mid-packet sequence
module tb_usb_rx_pkt_writer;
  localparam int MAX_PKT = 8;
  localparam int LSIZE = 4;
  logic CLK = 1'b0, RST = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0, rx_active = 1'b0, rx_error = 1'b0, fifo_full = 1'b0;
  logic fifo_write, fifo_pktval, fifo_rxact, pkt_done, pkt_err;
  logic [7:0] fifo_data;
  logic [3:0] pid;
  logic [LSIZE-1:0] pkt_len;
  logic [2:0] err_code;
  usb_rx_pkt_writer #(.MAX_PKT(MAX_PKT), .LSIZE(LSIZE)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_error(rx_error), .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_data(fifo_data),
    .fifo_pktval(fifo_pktval), .fifo_rxact(fifo_rxact), .pid(pid), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [7:0]       pid_b;
    int               n;
    logic [95:0]      b;
    bit               corrupt;
    int               full_at;
    int               err_at;
    int               exp_wr;
    bit               exp_done;
    logic [LSIZE-1:0] exp_len;
    logic [2:0]       exp_err;
  } vec_t;
  int errors = 0, checks = 0;
  logic [7:0] wq[$];
  int n_done = 0, n_pktval = 0, n_err = 0, bad_overlap = 0, bad_gap = 0, age = 0;
  bit wrote = 0;
  always @(negedge CLK) begin
    if (fifo_write) wq.push_back(fifo_data);
    if (pkt_done) n_done++;
    if (fifo_pktval) n_pktval++;
    if (pkt_err) n_err++;
    if (fifo_pktval && (fifo_write || !pkt_done)) bad_overlap++;
    age = fifo_rxact ? age + 1 : 0;
    if (!fifo_rxact) wrote = 0;
    if (fifo_write && !wrote) begin
      if (age < 4) bad_gap++;
      wrote = 1;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction
  task automatic apply(input vec_t v);
    logic [7:0] s[$];
    logic [15:0] c;
    logic [7:0] pb;
    int w0, d0, p0, e0, bad;
    c = 16'hFFFF;
    for (int i = 0; i < v.n; i++) c = crc16(c, v.b[95-8*i -: 8]);
    c = ~c;
    s.push_back(v.pid_b);
    for (int i = 0; i < v.n; i++) begin
      pb = v.b[95-8*i -: 8];
      s.push_back((v.corrupt && i == 1) ? pb ^ 8'h10 : pb);
    end
    s.push_back(c[7:0]);
    s.push_back(c[15:8]);
    w0 = wq.size(); d0 = n_done; p0 = n_pktval; e0 = n_err;
    check("rxact_low", fifo_rxact, 0);
    rx_active = 1'b1;
    step;
    check("rxact_rise", fifo_rxact, 1);
    for (int i = 0; i < s.size(); i++) begin
      rx_data = s[i];
      rx_valid = 1'b1;
      fifo_full = v.full_at >= 0 && i >= v.full_at;
      rx_error = i == v.err_at;
      step;
    end
    rx_valid = 1'b0; fifo_full = 1'b0; rx_error = 1'b0;
    step;
    rx_active = 1'b0;
    repeat (5) step;
    check("write_count", wq.size() - w0, v.exp_wr);
    bad = 0;
    for (int i = 0; i < v.exp_wr && w0 + i < wq.size(); i++) if (wq[w0+i] !== s[i+1]) bad++;
    check("write_data", bad, 0);
    check("pkt_done_count", n_done - d0, v.exp_done);
    check("pktval_count", n_pktval - p0, v.exp_done);
    check("pkt_err_count", n_err - e0, !v.exp_done);
    if (v.exp_done) begin
      check("pkt_len", pkt_len, v.exp_len);
      check("pid", pid, v.pid_b[3:0]);
    end else check("err_code", err_code, v.exp_err);
  endtask
  initial begin
    vec_t vt[9];
    int w0, d0, e0;
    vt[0] = '{8'hC3, 4, {32'h01020304, 64'h0}, 0, -1, -1, 4, 1, 4, 3'b000};
    vt[1] = '{8'hC3, 4, {32'h01020304, 64'h0}, 1, -1, -1, 4, 0, 0, 3'b001};
    vt[2] = '{8'h69, 0, 96'h0, 0, -1, -1, 0, 0, 0, 3'b001};
    vt[3] = '{8'hC4, 2, {16'h5566, 80'h0}, 0, -1, -1, 0, 0, 0, 3'b001};
    vt[4] = '{8'h4B, 0, 96'h0, 0, -1, -1, 0, 1, 0, 3'b000};
    vt[5] = '{8'hC3, 4, {32'h01020304, 64'h0}, 0, 5, -1, 2, 0, 0, 3'b010};
    vt[6] = '{8'hC3, 4, {32'h01020304, 64'h0}, 0, -1, 2, 0, 0, 0, 3'b100};
    vt[7] = '{8'h87, 9, {72'h112233445566778899, 24'h0}, 0, -1, -1, 8, 0, 0, 3'b010};
    vt[8] = '{8'h0F, 5, {40'hA55AFF0080, 56'h0}, 0, -1, -1, 5, 1, 5, 3'b000};
    repeat (3) step;
    check("reset_outputs", {fifo_write, fifo_data, fifo_pktval, fifo_rxact, pid, pkt_len,
                            pkt_done, pkt_err, err_code}, 0);
    RST = 1'b0;
    repeat (2) step;
    for (int t = 0; t < 9; t++) apply(vt[t]);
    rx_active = 1'b1;
    step;
    for (int i = 0; i < 4; i++) begin
      rx_data = (i == 0) ? 8'hC3 : 8'(i);
      rx_valid = 1'b1;
      step;
    end
    RST = 1'b1;
    rx_data = 8'h04;
    step;
    check("reset_mid_packet", {fifo_write, fifo_data, fifo_pktval, fifo_rxact, pid, pkt_len,
                               pkt_done, pkt_err, err_code}, 0);
    RST = 1'b0;
    w0 = wq.size(); d0 = n_done; e0 = n_err;
    for (int i = 5; i < 9; i++) begin
      rx_data = 8'(i);
      step;
    end
    rx_valid = 1'b0;
    step;
    rx_active = 1'b0;
    repeat (5) step;
    check("post_reset_writes", wq.size() - w0, 0);
    check("post_reset_pulses", (n_done - d0) + (n_err - e0), 0);
    apply(vt[0]);
    check("pktval_vs_write", bad_overlap, 0);
    check("first_write_gap", bad_gap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
